uart_tx_frame: RTL and testbench

Parametrised UART transmitter. Serialises words into asynchronous frames with compile-time data width, parity mode and stop-bit count. Accepts data on a valid/ready handshake into a one-entry holding register, so consecutive frames go out back-to-back with no idle gap. Sits between the system-side byte source and the board TX pin, and replaces the fixed 8N1 transmitter.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_bit_timer.sv | 28 ++
 rtl/uart_tx_frame.sv | 143 ++++++++++++++
 tb/tb_uart_tx_frame.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
// Parity modes, FSM state encoding and bit-period helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  function automatic int calc_bit_period(
    input int clk_freq,
    input int baud_rate
  );
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter with synchronous clear.
// bit_end is high on the last cycle of each bit period.
module uart_bit_timer #(
  parameter int BIT_PERIOD = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(BIT_PERIOD - 1);

  logic [W-1:0] count;

  assign bit_end = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clear || bit_end)
      count <= '0;
    else
      count <= count + 1'b1;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable data/parity/stop and a
// one-entry holding register for back-to-back frames.
module uart_tx_frame #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 frame_done
);

  import uart_pkg::*;

  localparam int BIT_PERIOD = calc_bit_period(CLK_FREQ, BAUD_RATE);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 ||
      PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      BIT_PERIOD < 2) begin : g_bad_param
    $error("uart_tx_frame: illegal parameter set");
  end

  tx_state_t            state;
  logic [DATA_BITS-1:0] hold_data;
  logic [DATA_BITS-1:0] shifter;
  logic                 hold_full;
  logic                 par_bit;
  logic                 load_par;
  logic                 bit_end;
  logic [3:0]           bit_cnt;
  logic                 accept;

  assign accept   = in_valid && in_ready;
  assign tx_busy  = (state != IDLE);
  assign load_par = (PARITY == PARITY_ODD) ? ~^hold_data : ^hold_data;

  // Timer idles at zero so START always gets a full bit period.
  uart_bit_timer #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state == IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      in_ready   <= 1'b1;
      frame_done <= 1'b0;
      hold_full  <= 1'b0;
      hold_data  <= '0;
      shifter    <= '0;
      par_bit    <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        hold_data <= in_data;
        hold_full <= 1'b1;
        in_ready  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (hold_full) begin
            shifter   <= hold_data;
            par_bit   <= load_par;
            hold_full <= 1'b0;
            in_ready  <= 1'b1;
            state     <= START;
            tx        <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shifter[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (PARITY != PARITY_NONE) begin
                state <= PAR;
                tx    <= par_bit;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shifter[1];
              shifter <= shifter >> 1;
            end
          end
        end
        PAR: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == LAST_STOP) begin
              frame_done <= 1'b1;
              bit_cnt    <= '0;
              // Held word goes straight out: no idle cycle between frames.
              if (hold_full) begin
                shifter   <= hold_data;
                par_bit   <= load_par;
                hold_full <= 1'b0;
                in_ready  <= 1'b1;
                state     <= START;
                tx        <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench: 8N1, 8E1, 8O1 and 7N2 transmitters at 16 clk/bit.
// Expected line bits are hand-built frames, bit 0 = start bit.
module tb_uart_tx_frame;

  typedef struct packed {
    logic [15:0] bits;
    logic [4:0]  n;
    logic        b2b;
    logic        abort;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] din;
  logic [3:0] val;
  wire  [3:0] rdy_v;
  wire  [3:0] tx_v;
  wire  [3:0] busy_v;
  wire  [3:0] fd_v;

  int checks;
  int failures;
  int sel;
  int t;
  int hold_bad;

  exp_t q[$];
  exp_t cur;
  bit   active;
  int   idx;
  int   cyc;
  int   done_cyc;
  int   bad;

  uart_tx_frame #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8),
                  .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(val[0]),
    .in_ready(rdy_v[0]), .tx(tx_v[0]), .tx_busy(busy_v[0]),
    .frame_done(fd_v[0]));

  uart_tx_frame #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8),
                  .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(val[1]),
    .in_ready(rdy_v[1]), .tx(tx_v[1]), .tx_busy(busy_v[1]),
    .frame_done(fd_v[1]));

  uart_tx_frame #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8),
                  .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .in_data(din[7:0]), .in_valid(val[2]),
    .in_ready(rdy_v[2]), .tx(tx_v[2]), .tx_busy(busy_v[2]),
    .frame_done(fd_v[2]));

  uart_tx_frame #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(7),
                  .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .in_data(din[6:0]), .in_valid(val[3]),
    .in_ready(rdy_v[3]), .tx(tx_v[3]), .tx_busy(busy_v[3]),
    .frame_done(fd_v[3]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: decodes whatever the selected transmitter puts on the line.
  initial begin
    active   = 1'b0;
    cyc      = 0;
    done_cyc = -10;
    idx      = 0;
    bad      = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (active)
          chk("frame cut by reset", {31'd0, cur.abort}, 1);
        active = 1'b0;
      end else begin
        if (active) begin
          idx++;
          if (idx == int'(cur.n) * 16) begin
            chk("frame_done at frame end", fd_v[sel], 1);
            done_cyc = cyc;
            active   = 1'b0;
          end else begin
            chk("frame_done inside frame", fd_v[sel], 0);
            if (tx_v[sel] !== cur.bits[idx/16]) bad++;
            if (idx % 16 == 15) begin
              chk($sformatf("line bit %0d", idx / 16), bad, 0);
              bad = 0;
            end
          end
        end else if (done_cyc != cyc) begin
          chk("spurious frame_done", fd_v[sel], 0);
        end
        if (!active && busy_v[sel] && tx_v[sel] == 1'b0) begin
          chk("frame expected", (q.size() != 0), 1);
          if (q.size() != 0) begin
            cur    = q.pop_front();
            active = 1'b1;
            idx    = 0;
            bad    = 0;
            if (cur.b2b) chk("back-to-back start cycle", cyc, done_cyc);
          end
        end
      end
    end
  end

  task automatic send(input int ch, input logic [7:0] d,
                      input logic [15:0] bits, input int n,
                      input bit b2b, input bit abort, input bit keep);
    exp_t e;
    int   w;
    din     = d;
    val[ch] = 1'b1;
    w = 0;
    while (!rdy_v[ch] && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!rdy_v[ch]) chk("in_ready timeout", rdy_v[ch], 1);
    @(posedge clk);
    e.bits  = bits;
    e.n     = 5'(n);
    e.b2b   = b2b;
    e.abort = abort;
    q.push_back(e);
    @(negedge clk);
    if (!keep) val[ch] = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((active || q.size() != 0 || busy_v[sel]) && w < 3000);
    chk("idle queue empty", q.size(), 0);
    chk("idle busy low", busy_v[sel], 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    sel      = 0;
    rst      = 1'b1;
    din      = 8'h00;
    val      = 4'h0;
    @(posedge clk);
    #2;
    chk("reset tx", tx_v, 4'hF);
    chk("reset busy", busy_v, 4'h0);
    chk("reset ready", rdy_v, 4'hF);
    chk("reset frame_done", fd_v, 4'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // 8N1 0x55 with accept-to-start latency
    sel = 0;
    send(0, 8'h55, 16'h02AA, 10, 0, 0, 0);
    chk("latency ready low", rdy_v[0], 0);
    chk("latency tx idle", tx_v[0], 1);
    chk("latency busy low", busy_v[0], 0);
    @(negedge clk);
    chk("start bit tx", tx_v[0], 0);
    chk("start bit busy", busy_v[0], 1);
    chk("ready after load", rdy_v[0], 1);
    wait_idle();

    // 8E1 and 8O1 0x07
    sel = 1;
    send(1, 8'h07, 16'h060E, 11, 0, 0, 0);
    wait_idle();
    sel = 2;
    send(2, 8'h07, 16'h040E, 11, 0, 0, 0);
    wait_idle();

    // back-to-back 0xA5, 0x3C with valid held
    sel = 0;
    send(0, 8'hA5, 16'h034A, 10, 0, 0, 1);
    send(0, 8'h3C, 16'h0278, 10, 1, 0, 0);
    chk("ready low while held", rdy_v[0], 0);
    t = 0;
    hold_bad = 0;
    while (!fd_v[0] && t < 400) begin
      @(negedge clk);
      t++;
      if (!fd_v[0] && rdy_v[0]) hold_bad++;
    end
    chk("first frame_done seen", fd_v[0], 1);
    chk("ready stayed low", hold_bad, 0);
    chk("ready at second load", rdy_v[0], 1);
    wait_idle();

    // 7N2 0x7F
    sel = 3;
    send(3, 8'hFF, 16'h03FE, 10, 0, 0, 0);
    wait_idle();

    // reset during data bit 3, then 0x81
    sel = 0;
    send(0, 8'h5A, 16'h02B4, 10, 0, 1, 0);
    t = 0;
    while (!busy_v[0] && t < 10) begin
      @(negedge clk);
      t++;
    end
    repeat (72) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst tx", tx_v[0], 1);
    chk("async rst busy", busy_v[0], 0);
    chk("async rst ready", rdy_v[0], 1);
    chk("async rst frame_done", fd_v[0], 0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("queue drained by abort", q.size(), 0);
    send(0, 8'h81, 16'h0302, 10, 0, 0, 0);
    wait_idle();

    // in_data changes right after accept
    send(0, 8'hC3, 16'h0386, 10, 0, 0, 0);
    din = 8'h00;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
